// File: rtl/in_fm_tile_scheduler_pkg.sv
// Shared types and helpers for the in-fm tile scheduler.
// Holds the FSM encoding and a tile-count helper for the benches.
package in_fm_tile_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOAD,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  function automatic int unsigned tile_total(
    input int unsigned m,
    input int unsigned r,
    input int unsigned c,
    input int unsigned tm,
    input int unsigned tr,
    input int unsigned tc
  );
    return (m / tm) * (r / tr) * (c / tc);
  endfunction

endpackage

// File: rtl/in_fm_tile_scheduler_if.sv
// Control/loader/conv-core bundle of the in-fm tile scheduler.
// master = scheduler side, slave = layer control + loader + core side.
interface in_fm_tile_scheduler_if
  import in_fm_tile_scheduler_pkg::*;
#(
  parameter int CW = 32
);

  logic          sched_start;
  logic          sched_busy;
  logic          sched_done;
  logic          load_start;
  logic          load_done;
  logic          tile_consumed;
  logic [CW-1:0] tile_base_m;
  logic [CW-1:0] tile_base_row;
  logic [CW-1:0] tile_base_col;
  logic          last_tile;
  logic [CW-1:0] tile_cnt;
  logic          err;

  modport master (
    input  sched_start,
    input  load_done,
    input  tile_consumed,
    output sched_busy,
    output sched_done,
    output load_start,
    output tile_base_m,
    output tile_base_row,
    output tile_base_col,
    output last_tile,
    output tile_cnt,
    output err
  );

  modport slave (
    output sched_start,
    output load_done,
    output tile_consumed,
    input  sched_busy,
    input  sched_done,
    input  load_start,
    input  tile_base_m,
    input  tile_base_row,
    input  tile_base_col,
    input  last_tile,
    input  tile_cnt,
    input  err
  );

endinterface

// File: rtl/in_fm_tile_scheduler_tile_loop_cnt.sv
// Nested m/col/row wrap counter for in-fm tile bases.
// m is innermost, row outermost; adders only.
module in_fm_tile_scheduler_tile_loop_cnt
  import in_fm_tile_scheduler_pkg::*;
#(
  parameter int CW = 32,
  parameter int M  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tm = 8,
  parameter int Tr = 16,
  parameter int Tc = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] m,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [CW-1:0] M_LAST = CW'(M - Tm);
  localparam logic [CW-1:0] R_LAST = CW'(R - Tr);
  localparam logic [CW-1:0] C_LAST = CW'(C - Tc);
  localparam logic [CW-1:0] M_STEP = CW'(Tm);
  localparam logic [CW-1:0] R_STEP = CW'(Tr);
  localparam logic [CW-1:0] C_STEP = CW'(Tc);

  logic m_wrap;
  logic col_wrap;
  logic row_wrap;

  assign m_wrap   = (m == M_LAST);
  assign col_wrap = (col == C_LAST);
  assign row_wrap = (row == R_LAST);
  assign last     = m_wrap && col_wrap && row_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m   <= '0;
      row <= '0;
      col <= '0;
    end else if (clr) begin
      m   <= '0;
      row <= '0;
      col <= '0;
    end else if (step) begin
      m <= m_wrap ? '0 : m + M_STEP;
      if (m_wrap) begin
        col <= col_wrap ? '0 : col + C_STEP;
        if (col_wrap) begin
          row <= row_wrap ? '0 : row + R_STEP;
        end
      end
    end
  end

endmodule

// File: rtl/in_fm_tile_scheduler.sv
// Issues in-fm tile loads over the whole M x R x C volume,
// throttled by a credit count of free downstream tile buffers.
module in_fm_tile_scheduler
  import in_fm_tile_scheduler_pkg::*;
#(
  parameter int CW      = 32,
  parameter int M       = 32,
  parameter int R       = 64,
  parameter int C       = 32,
  parameter int Tm      = 8,
  parameter int Tr      = 16,
  parameter int Tc      = 8,
  parameter int BUF_NUM = 2
) (
  input logic clk,
  input logic rst,
  in_fm_tile_scheduler_if.master bus
);

  if ((M % Tm) != 0 || (R % Tr) != 0 || (C % Tc) != 0 ||
      BUF_NUM < 1 || BUF_NUM > 2) begin : g_bad_cfg
    $error("in_fm_tile_scheduler: illegal tiling parameters");
  end

  localparam logic [1:0] CR_MAX = 2'(BUF_NUM);

  sched_state_t  state;
  logic [1:0]    credits;
  logic [1:0]    credits_nxt;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          issue;
  logic          cons_ok;
  logic          err_evt;
  logic          start_acc;
  logic          step;
  logic          last;
  logic [CW-1:0] base_m;
  logic [CW-1:0] base_row;
  logic [CW-1:0] base_col;

  assign start_acc = (state == S_IDLE) && bus.sched_start;
  assign issue     = (state == S_ISSUE) && (credits < CR_MAX);
  assign cons_ok   = bus.tile_consumed && (credits != 2'd0);
  assign step      = (state == S_WAIT_LOAD) && bus.load_done && !last;

  // A consume with no credit is an error and must not underflow.
  assign credits_nxt = credits + {1'b0, issue} - {1'b0, cons_ok};

  assign err_evt =
    (bus.tile_consumed && (credits == 2'd0)) ||
    (bus.load_done && (state != S_WAIT_LOAD));

  in_fm_tile_scheduler_tile_loop_cnt #(
    .CW (CW),
    .M  (M),
    .R  (R),
    .C  (C),
    .Tm (Tm),
    .Tr (Tr),
    .Tc (Tc)
  ) u_loop (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .step (step),
    .m    (base_m),
    .row  (base_row),
    .col  (base_col),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      credits <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      credits <= credits_nxt;
      if (err_evt) begin
        err_q <= 1'b1;
      end
      if (issue) begin
        cnt <= cnt + CW'(1);
      end
      unique case (state)
        S_IDLE: begin
          if (bus.sched_start) begin
            state <= S_ISSUE;
            cnt   <= '0;
            err_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            state <= S_WAIT_LOAD;
          end
        end
        S_WAIT_LOAD: begin
          if (bus.load_done) begin
            state <= last ? S_DRAIN : S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (credits_nxt == 2'd0) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sched_busy    = (state != S_IDLE);
  assign bus.sched_done    = (state == S_DONE);
  assign bus.load_start    = issue;
  assign bus.tile_base_m   = base_m;
  assign bus.tile_base_row = base_row;
  assign bus.tile_base_col = base_col;
  assign bus.last_tile     = last;
  assign bus.tile_cnt      = cnt;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_in_fm_tile_scheduler.sv
// Bench: BUF_NUM=1 and BUF_NUM=2 schedulers side by side,
// emulated loader/core, count-level reference model per instance.
module tb_in_fm_tile_scheduler;
  import in_fm_tile_scheduler_pkg::*;

  localparam int CW = 32;
  localparam int M  = 32;
  localparam int R  = 64;
  localparam int C  = 32;
  localparam int Tm = 8;
  localparam int Tr = 16;
  localparam int Tc = 8;
  localparam int TOTAL = (M / Tm) * (R / Tr) * (C / Tc);

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic inj_cons;
  logic inj_ld;
  int   cyc = 0;
  int   mode = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic void base_of(input int k, output int bm,
                                  output int br, output int bc);
    bm = (k % (M / Tm)) * Tm;
    bc = ((k / (M / Tm)) % (C / Tc)) * Tc;
    br = (k / ((M / Tm) * (C / Tc))) * Tr;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int BN = g + 1;

    in_fm_tile_scheduler_if #(.CW(CW)) ifc ();
    logic ld = 1'b0;
    logic cs = 1'b0;

    assign ifc.sched_start   = start;
    assign ifc.load_done     = ld | inj_ld;
    assign ifc.tile_consumed = cs | inj_cons;

    in_fm_tile_scheduler #(
      .CW(CW), .M(M), .R(R), .C(C),
      .Tm(Tm), .Tr(Tr), .Tc(Tc), .BUF_NUM(BN)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.master)
    );

    // loader answers after a delay; core consumes in order after a delay
    initial begin : env
      int ld_due;
      int last_due;
      int d;
      int due;
      int cq[$];
      ld_due = -1;
      last_due = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          ld_due = -1;
          last_due = 0;
          cq.delete();
        end else begin
          if (ifc.load_start)
            ld_due = cyc + ((mode == 0) ? 5 : $urandom_range(1, 4));
          if (ifc.load_done && ld) begin
            d = (mode == 0) ? ((BN == 1) ? 10 : 30) : $urandom_range(1, 4);
            due = cyc + d;
            if (due <= last_due) due = last_due + 1;
            cq.push_back(due);
            last_due = due;
          end
        end
        @(posedge clk);
        #1;
        ld = (cyc == ld_due);
        cs = (cq.size() > 0 && cq[0] == cyc);
        if (cs) void'(cq.pop_front());
      end
    end

    bit active, waiting, done_now, err_e;
    int issued, outst, pass_cons, done_cnt, simul_hits;
    int cons1_cyc, last_cons_cyc, done_cyc;
    int ls_cyc[3];

    initial begin : model
      bit ls_e, cons, cons_ok, ldn, st_acc, drain;
      int k, em, er, ec;
      string p;
      p = $sformatf("bn%0d_", BN);
      active = 0; waiting = 0; done_now = 0; err_e = 0;
      issued = 0; outst = 0; pass_cons = 0; done_cnt = 0; simul_hits = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          active = 0; waiting = 0; done_now = 0; err_e = 0;
          issued = 0; outst = 0;
        end else begin
          ls_e = active && !done_now && !waiting &&
                 issued < TOTAL && outst < BN;
          chk({p, "busy"}, ifc.sched_busy, active);
          chk({p, "done"}, ifc.sched_done, done_now);
          chk({p, "load_start"}, ifc.load_start, ls_e);
          chk({p, "tile_cnt"}, ifc.tile_cnt, issued);
          chk({p, "err"}, ifc.err, err_e);
          if (done_now) begin
            done_cyc = cyc;
            done_cnt++;
          end
          if (active && !done_now && (waiting || issued < TOTAL)) begin
            k = waiting ? issued - 1 : issued;
            base_of(k, em, er, ec);
            chk({p, "base_m"}, ifc.tile_base_m, em);
            chk({p, "base_row"}, ifc.tile_base_row, er);
            chk({p, "base_col"}, ifc.tile_base_col, ec);
            chk({p, "last_tile"}, ifc.last_tile, (k == TOTAL - 1));
          end
          cons   = ifc.tile_consumed;
          ldn    = ifc.load_done;
          st_acc = ifc.sched_start && !active;
          drain  = active && !done_now && !waiting && issued == TOTAL;
          cons_ok = cons && outst > 0;
          if (cons && outst == 0) err_e = 1;
          if (ls_e && cons && outst == 1) simul_hits++;
          if (cons && active) begin
            pass_cons++;
            if (pass_cons == 1) cons1_cyc = cyc;
            if (pass_cons == TOTAL) last_cons_cyc = cyc;
          end
          if (ldn) begin
            if (waiting) waiting = 0;
            else err_e = 1;
          end
          outst = outst - (cons_ok ? 1 : 0) + (ls_e ? 1 : 0);
          if (ls_e) begin
            if (issued < 3) ls_cyc[issued] = cyc;
            issued++;
            waiting = 1;
          end
          if (done_now) begin
            done_now = 0;
            active = 0;
          end else if (drain && outst == 0) begin
            done_now = 1;
          end
          if (st_acc) begin
            active = 1; issued = 0; waiting = 0;
            err_e = 0; pass_cons = 0;
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int t1);
    int n = 0;
    while ((g_inst[0].done_cnt < t0 || g_inst[1].done_cnt < t1) &&
           n < 30000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("pass_done_in_time", (n < 30000), 1);
  endtask

  task automatic wait_issued(input int k);
    int n = 0;
    while (g_inst[0].issued < k && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("issued_in_time", (n < 20000), 1);
  endtask

  task automatic check_zero(input string t);
    chk({t, "_flags0"}, {g_inst[0].ifc.sched_busy, g_inst[0].ifc.sched_done,
        g_inst[0].ifc.load_start, g_inst[0].ifc.last_tile,
        g_inst[0].ifc.err}, 0);
    chk({t, "_bases0"}, g_inst[0].ifc.tile_base_m |
        g_inst[0].ifc.tile_base_row | g_inst[0].ifc.tile_base_col, 0);
    chk({t, "_cnt0"}, g_inst[0].ifc.tile_cnt, 0);
    chk({t, "_flags1"}, {g_inst[1].ifc.sched_busy, g_inst[1].ifc.sched_done,
        g_inst[1].ifc.load_start, g_inst[1].ifc.last_tile,
        g_inst[1].ifc.err}, 0);
    chk({t, "_bases1"}, g_inst[1].ifc.tile_base_m |
        g_inst[1].ifc.tile_base_row | g_inst[1].ifc.tile_base_col, 0);
    chk({t, "_cnt1"}, g_inst[1].ifc.tile_cnt, 0);
  endtask

  initial begin : main
    int bm, br, bc, d0, d1, n;
    rst = 1'b1; start = 1'b0; inj_cons = 1'b0; inj_ld = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    chk("pkg_tile_total", tile_total(M, R, C, Tm, Tr, Tc), 64);
    base_of(1, bm, br, bc);
    chk("model_base1_m", bm, 8);
    base_of(4, bm, br, bc);
    chk("model_base4", {bm[7:0], br[7:0], bc[7:0]}, {8'd0, 8'd0, 8'd8});
    base_of(63, bm, br, bc);
    chk("model_base63", {bm[7:0], br[7:0], bc[7:0]}, {8'd24, 8'd48, 8'd24});

    // pass A: fixed loader/core latencies
    mode = 0;
    d0 = g_inst[0].done_cnt; d1 = g_inst[1].done_cnt;
    pulse_start();
    wait_done(d0 + 1, d1 + 1);
    chk("bn1_cons_total", g_inst[0].pass_cons, 64);
    chk("bn1_done_after_last_cons",
        (g_inst[0].done_cyc > g_inst[0].last_cons_cyc), 1);
    chk("bn1_tile_cnt", g_inst[0].ifc.tile_cnt, 64);
    chk("bn2_ls2_before_cons1",
        (g_inst[1].ls_cyc[1] < g_inst[1].cons1_cyc), 1);
    chk("bn2_ls3_after_cons1",
        (g_inst[1].ls_cyc[2] > g_inst[1].cons1_cyc), 1);

    // late consume while idle with no credits
    @(posedge clk); #1 inj_cons = 1'b1;
    @(posedge clk); #1 inj_cons = 1'b0;
    @(negedge clk);
    chk("idle_cons_err0", g_inst[0].ifc.err, 1);
    chk("idle_cons_err1", g_inst[1].ifc.err, 1);
    repeat (5) @(negedge clk);
    chk("idle_cons_err_held", g_inst[0].ifc.err & g_inst[1].ifc.err, 1);

    // pass B: random latencies, restart attempt at tile 10
    mode = 1;
    d0 = g_inst[0].done_cnt; d1 = g_inst[1].done_cnt;
    pulse_start();
    @(negedge clk);
    chk("start_clears_err", g_inst[0].ifc.err | g_inst[1].ifc.err, 0);
    wait_issued(10);
    pulse_start();
    wait_issued(11);
    @(posedge clk); #1;
    chk("busy_start_cnt11", g_inst[0].ifc.tile_cnt, 11);
    wait_issued(12);
    @(posedge clk); #1;
    chk("busy_start_cnt12", g_inst[0].ifc.tile_cnt, 12);
    wait_done(d0 + 1, d1 + 1);
    chk("passb_cnt0", g_inst[0].ifc.tile_cnt, 64);
    chk("passb_cnt1", g_inst[1].ifc.tile_cnt, 64);

    // pass C: async reset while waiting on load 20
    pulse_start();
    n = 0;
    while (!(g_inst[0].issued == 20 && g_inst[0].waiting) && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_tile20", (n < 20000), 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk); #3 rst = 1'b0;
    d0 = g_inst[0].done_cnt; d1 = g_inst[1].done_cnt;
    pulse_start();
    n = 0;
    while (!g_inst[0].ifc.load_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("restart_load_start", g_inst[0].ifc.load_start, 1);
    chk("restart_base", g_inst[0].ifc.tile_base_m |
        g_inst[0].ifc.tile_base_row | g_inst[0].ifc.tile_base_col, 0);
    chk("restart_cnt", g_inst[0].ifc.tile_cnt, 0);
    wait_done(d0 + 1, d1 + 1);

    // stray load_done while idle
    @(posedge clk); #1 inj_ld = 1'b1;
    @(posedge clk); #1 inj_ld = 1'b0;
    @(negedge clk);
    chk("idle_load_done_err", g_inst[0].ifc.err & g_inst[1].ifc.err, 1);
    chk("bn2_simul_ls_cons_seen", (g_inst[1].simul_hits > 0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/in_fm_tile_scheduler.md
# in_fm_tile_scheduler

Sequences input-feature-map tile loads across the whole in_fm[M][R][C] volume. It generates tile_base_m/row/col for the in-fm RAM-to-FIFO loader, pulses its start, and waits for its done. It also throttles loads against the convolution core's tile consumption using a credit count of free tile buffers. It sits between the layer-level control and the in-fm loader / conv core pair.

## Interface
- CW, 32, counter/base width
- M, 32, input channels
- R, 64, rows
- C, 32, columns
- Tm, 8, tile channels; M % Tm == 0, checked at elaboration
- Tr, 16, tile rows; R % Tr == 0
- Tc, 8, tile cols; C % Tc == 0
- BUF_NUM, 2, tile buffers downstream (1 or 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sched_start  in  1  one-cycle pulse; begin a full-volume pass
- sched_busy  out  1  high from the cycle after an accepted sched_start until sched_done
- sched_done  out  1  one-cycle pulse; all tiles loaded and consumed
- load_start  out  1  one-cycle pulse to the loader
- load_done  in  1  one-cycle pulse from the loader
- tile_consumed  in  1  one-cycle pulse from the conv core; one tile buffer freed
- tile_base_m  out  CW  channel base of the current tile
- tile_base_row  out  CW  row base
- tile_base_col  out  CW  column base
- last_tile  out  1  current tile is the final tile of the pass
- tile_cnt  out  CW  tiles issued in this pass
- err  out  1  sticky protocol error; cleared by rst or an accepted sched_start

## Operation
- States: IDLE, ISSUE, WAIT_LOAD, DRAIN, DONE.
- IDLE:
  - sched_start clears the m/row/col counters, tile_cnt and err, then goes to ISSUE.
  - sched_start in any other state is ignored (no err).
- ISSUE:
  - If credits < BUF_NUM: assert load_start (combinational from state and credits), credits+1, tile_cnt+1, go to WAIT_LOAD.
  - Otherwise hold in ISSUE.
- WAIT_LOAD:
  - tile_base_* and last_tile are held stable.
  - On load_done: if last_tile, go to DRAIN. Otherwise advance the counters and go to ISSUE.
- Loop order is m innermost, then col, then row outermost.
  - tile_base_m steps by Tm and wraps to 0 at M; on that wrap, col steps by Tc.
  - col wraps to 0 at C; on that wrap, row steps by Tr.
  - Counters use additions only, no multipliers.
- last_tile = (m == M-Tm) && (col == C-Tc) && (row == R-Tr).
- DRAIN: wait until credits == 0, evaluated after this cycle's tile_consumed, then go to DONE.
- DONE: sched_done = 1 for one cycle, then IDLE.
- Credits:
  - load_start increments; tile_consumed decrements.
  - Both in the same cycle leave credits unchanged.
  - Credits are only ever in 0..BUF_NUM.
- Errors set err and are otherwise ignored:
  - tile_consumed with credits == 0.
  - load_done outside WAIT_LOAD.
- tile_consumed is accepted in every state, including IDLE, for late consumption.

## Timing
- Reset values:
  - State IDLE; credits 0.
  - All tile_base_*, tile_cnt, sched_busy, sched_done, load_start, last_tile and err are 0.
- sched_start at edge t gives ISSUE at t+1, so load_start is high in cycle t+1 if a credit is available.
- load_done at edge t, not last tile: tile_base_* updated and load_start possible in cycle t+1.
  - This gives a 1-cycle bubble between loads.
- Last load_done at edge t with credits already 0: DRAIN in t+1 and sched_done in cycle t+2.
- With BUF_NUM=1, a load overlaps no compute. With BUF_NUM=2, the next tile is loaded while the conv core consumes the previous one.
- Reset mid-operation returns everything to the reset values immediately.
  - The loader and conv core are reset by the same rst.

## Structure
- Shared package: the state encoding enum and a function computing tile count (M/Tm)*(R/Tr)*(C/Tc) for the benches.
- One natural sub-module: tile_loop_cnt, the nested 3-level wrap counter with a step input and last output.
- The credit counter and FSM stay in the top module.

## Test plan
- Default parameters, BUF_NUM=1:
  - Stimulus: the loader answers load_done 5 cycles after load_start; the conv core answers tile_consumed 10 cycles after load_done.
  - Required: 64 loads. Base sequence (m,row,col) = (0,0,0),(8,0,0),(16,0,0),(24,0,0),(0,0,8)…(24,48,24).
  - Required: sched_done is 1 cycle and comes after the 64th tile_consumed; tile_cnt=64.
- BUF_NUM=2, consumer slow (30 cycles per tile):
  - Required: the 2nd load_start occurs before the 1st tile_consumed.
  - Required: the 3rd load_start never precedes the 1st tile_consumed.
- Simultaneous load_start and tile_consumed in one cycle with credits=1:
  - Required: credits stay 1; no err.
- tile_consumed in IDLE with credits=0:
  - Required: err=1 and held; the next sched_start clears it.
- sched_start pulsed while busy at tile 10:
  - Required: ignored; tile_cnt continues 11, 12, … with no restart.
- rst asserted while in WAIT_LOAD at tile 20:
  - Required: outputs return to 0 asynchronously.
  - Required: a new sched_start restarts from base (0,0,0).
